// File: rtl/baudgen_prog.sv
// rtl/baudgen_prog.sv - runtime-programmable baud tick generator (bit-start and mid-bit ticks)
//
// Optional fractional divisor: define BAUDGEN_FRAC_EN. Without it every period
// is exactly div_r clocks and frac_val is ignored.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   clk_ena   1 = generate ticks, 0 = stopped (counter held at 0)
//   div_load  one-cycle strobe: load div_val (and frac_val)
//   div_val   new integer divisor, system clocks per bit (must be >= 2)
//   frac_val  new fractional divisor in 1/2^FRAC_W clock units
//   tick_bit  one-cycle pulse at each bit start
//   tick_mid  one-cycle pulse at mid-bit
//   div_cur   currently active integer divisor
//   div_err   one-cycle pulse after a rejected load
module baudgen_prog #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1250,
  parameter int FRAC_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_ena,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [FRAC_W-1:0] frac_val,
  output logic              tick_bit,
  output logic              tick_mid,
  output logic [DIV_W-1:0]  div_cur,
  output logic              div_err
);

  localparam logic [DIV_W-1:0] DIV_MAX = '1;
  localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] pend_div;
  logic             pend_vld;
  logic             extra;
  logic [DIV_W-1:0] period_last;
  logic             wrap;
  logic             load_ok;
  logic             apply_now;
  logic             apply_pend;

  // extra is only ever set when div_r < DIV_MAX, so this cannot overflow
  assign period_last = div_r - DIV_W'(1) + {{(DIV_W-1){1'b0}}, extra};
  assign wrap        = clk_ena && (cnt == period_last);
  assign load_ok     = div_load && (div_val >= DIV_W'(2));
  // Stopped or at a period boundary: a new divisor can take effect at once
  assign apply_now   = load_ok && (!clk_ena || wrap);
  assign apply_pend  = !load_ok && wrap && pend_vld;

  assign tick_bit = clk_ena && (cnt == '0) && !rst;
  assign tick_mid = clk_ena && (cnt == (div_r >> 1)) && !rst;
  assign div_cur  = div_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!clk_ena || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r    <= DIV_DEF;
      pend_div <= '0;
      pend_vld <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_err <= div_load && !load_ok;
      if (apply_now) begin
        div_r    <= div_val;
        pend_vld <= 1'b0;
      end else if (load_ok) begin
        // Running mid-period: hold until the wrap, last writer wins
        pend_div <= div_val;
        pend_vld <= 1'b1;
      end else if (apply_pend) begin
        div_r    <= pend_div;
        pend_vld <= 1'b0;
      end
    end
  end

`ifdef BAUDGEN_FRAC_EN
  logic [FRAC_W-1:0] frac_r;
  logic [FRAC_W-1:0] pend_frac;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;
  logic              frac_step;

  assign acc_sum   = {1'b0, acc} + {1'b0, frac_r};
  assign frac_step = wrap && !load_ok && !pend_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_r    <= '0;
      pend_frac <= '0;
      acc       <= '0;
      extra     <= 1'b0;
    end else if (apply_now) begin
      frac_r <= frac_val;
      acc    <= '0;
      extra  <= 1'b0;
    end else if (load_ok) begin
      pend_frac <= frac_val;
    end else if (apply_pend) begin
      frac_r <= pend_frac;
      acc    <= '0;
      extra  <= 1'b0;
    end else if (frac_step) begin
      // Carry out of the accumulator stretches the next period by one clock;
      // suppressed at the largest divisor so the counter cannot overflow
      acc   <= acc_sum[FRAC_W-1:0];
      extra <= acc_sum[FRAC_W] && (div_r != DIV_MAX);
    end
  end
`else
  logic unused_frac;
  assign extra       = 1'b0;
  assign unused_frac = ^frac_val;
`endif

endmodule

// File: tb/tb_baudgen_prog.sv
// tb/tb_baudgen_prog.sv - directed self-checking bench for baudgen_prog
module tb_baudgen_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_ena = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_val = '0;
  logic [7:0]  frac_val = '0;
  logic        tick_bit;
  logic        tick_mid;
  logic [15:0] div_cur;
  logic        div_err;

  int n_checks = 0;
  int n_fail = 0;

  bit rec_on = 1'b0;
  int rec_cyc = 0;
  int got_bit[$];
  int got_mid[$];

  baudgen_prog #(.DIV_W(16), .DEFAULT_DIV(1250), .FRAC_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_ena  (clk_ena),
    .div_load (div_load),
    .div_val  (div_val),
    .frac_val (frac_val),
    .tick_bit (tick_bit),
    .tick_mid (tick_mid),
    .div_cur  (div_cur),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  // Cycle n is the low phase starting at the n-th negedge after start_rec
  always @(negedge clk) begin
    #2;
    if (rec_on) begin
      if (tick_bit === 1'b1) got_bit.push_back(rec_cyc);
      if (tick_mid === 1'b1) got_mid.push_back(rec_cyc);
      rec_cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_rec();
    got_bit.delete();
    got_mid.delete();
    rec_cyc = 0;
    rec_on = 1'b1;
  endtask

  task automatic stop_rec();
    #3;
    rec_on = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clk_ena = 1'b0;
    div_load = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  task automatic load(input logic [15:0] d, input logic [7:0] f);
    div_load = 1'b1;
    div_val = d;
    frac_val = f;
    step(1);
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clk_ena = 1'b1;
    step(2);
    #1;
    n_checks++;
    if (tick_bit !== 1'b0 || tick_mid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ticks got bit=%b mid=%b exp 0 0", tick_bit, tick_mid);
    end
    n_checks++;
    if (div_cur !== 16'd1250) begin
      n_fail++;
      $display("FAIL reset_div_cur got=%0d exp=1250", div_cur);
    end
    n_checks++;
    if (div_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_div_err got=%b exp=0", div_err);
    end
    clk_ena = 1'b0;
  endtask

  task automatic test_default_rate();
    int eb[$];
    int em[$];
    eb = '{0, 1250, 2500};
    em = '{625, 1875};
    apply_reset();
    clk_ena = 1'b1;
    start_rec();
    step(2500);
    stop_rec();
    n_checks++;
    if (got_bit != eb) begin
      n_fail++;
      $display("FAIL default_bit got=%p exp=%p", got_bit, eb);
    end
    n_checks++;
    if (got_mid != em) begin
      n_fail++;
      $display("FAIL default_mid got=%p exp=%p", got_mid, em);
    end
  endtask

  task automatic test_enable_gap();
    int eb[$];
    int em[$];
    eb = '{0, 420, 1670};
    em = '{1045};
    apply_reset();
    clk_ena = 1'b1;
    start_rec();
    step(400);
    clk_ena = 1'b0;
    step(20);
    clk_ena = 1'b1;
    #1;
    n_checks++;
    if (tick_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL reenable_tick got=%b exp=1", tick_bit);
    end
    step(1280);
    stop_rec();
    n_checks++;
    if (got_bit != eb) begin
      n_fail++;
      $display("FAIL gap_bit got=%p exp=%p", got_bit, eb);
    end
    n_checks++;
    if (got_mid != em) begin
      n_fail++;
      $display("FAIL gap_mid got=%p exp=%p", got_mid, em);
    end
  endtask

  task automatic test_load_running();
    int eb[$];
    int em[$];
    eb = '{0, 1250, 2118, 2986};
    em = '{625, 1684, 2552};
    apply_reset();
    clk_ena = 1'b1;
    start_rec();
    step(100);
    load(16'd868, 8'h00);
    step(1148);
    #1;
    n_checks++;
    if (div_cur !== 16'd1250) begin
      n_fail++;
      $display("FAIL pending_div_cur got=%0d exp=1250", div_cur);
    end
    step(1);
    #1;
    n_checks++;
    if (div_cur !== 16'd868) begin
      n_fail++;
      $display("FAIL applied_div_cur got=%0d exp=868", div_cur);
    end
    step(1750);
    stop_rec();
    n_checks++;
    if (got_bit != eb) begin
      n_fail++;
      $display("FAIL load_bit got=%p exp=%p", got_bit, eb);
    end
    n_checks++;
    if (got_mid != em) begin
      n_fail++;
      $display("FAIL load_mid got=%p exp=%p", got_mid, em);
    end
  endtask

  task automatic test_back_to_back();
    int eb[$];
    eb = '{0, 1250, 2118};
    apply_reset();
    clk_ena = 1'b1;
    start_rec();
    step(100);
    load(16'd500, 8'h00);
    step(99);
    load(16'd868, 8'h00);
    step(1920);
    stop_rec();
    n_checks++;
    if (got_bit != eb) begin
      n_fail++;
      $display("FAIL last_writer_bit got=%p exp=%p", got_bit, eb);
    end
  endtask

  task automatic test_load_on_wrap();
    int eb[$];
    int em[$];
    eb = '{0, 1250, 2118};
    em = '{625, 1684};
    apply_reset();
    clk_ena = 1'b1;
    start_rec();
    step(1249);
    load(16'd868, 8'h00);
    step(869);
    stop_rec();
    n_checks++;
    if (got_bit != eb || got_mid != em) begin
      n_fail++;
      $display("FAIL wrap_load got bit=%p mid=%p exp bit=%p mid=%p", got_bit, got_mid, eb, em);
    end
  endtask

  task automatic test_div_min();
    int eb[$];
    int em[$];
    eb = '{0, 2, 4, 6};
    em = '{1, 3, 5};
    apply_reset();
    load(16'd2, 8'h00);
    #1;
    n_checks++;
    if (div_cur !== 16'd2 || div_err !== 1'b0) begin
      n_fail++;
      $display("FAIL min_load got div=%0d err=%b exp div=2 err=0", div_cur, div_err);
    end
    @(negedge clk);
    clk_ena = 1'b1;
    start_rec();
    step(6);
    stop_rec();
    n_checks++;
    if (got_bit != eb || got_mid != em) begin
      n_fail++;
      $display("FAIL min_ticks got bit=%p mid=%p exp bit=%p mid=%p", got_bit, got_mid, eb, em);
    end
  endtask

  task automatic test_load_error();
    int eb[$];
    eb = '{0, 1250, 2500};
    apply_reset();
    clk_ena = 1'b1;
    start_rec();
    step(200);
    #1;
    n_checks++;
    if (div_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_idle got=%b exp=0", div_err);
    end
    load(16'd1, 8'h00);
    #1;
    n_checks++;
    if (div_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_div1 got=%b exp=1", div_err);
    end
    step(1);
    #1;
    n_checks++;
    if (div_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_width got=%b exp=0", div_err);
    end
    step(98);
    load(16'd0, 8'h00);
    #1;
    n_checks++;
    if (div_err !== 1'b1 || div_cur !== 16'd1250) begin
      n_fail++;
      $display("FAIL err_div0 got err=%b div=%0d exp err=1 div=1250", div_err, div_cur);
    end
    step(2199);
    stop_rec();
    n_checks++;
    if (got_bit != eb) begin
      n_fail++;
      $display("FAIL err_spacing got=%p exp=%p", got_bit, eb);
    end
  endtask

  task automatic test_fraction();
    int eb[$];
`ifdef BAUDGEN_FRAC_EN
    eb = '{0, 10, 20, 31, 41, 52};
`else
    eb = '{0, 10, 20, 30, 40, 50};
`endif
    apply_reset();
    load(16'd10, 8'h80);
    @(negedge clk);
    clk_ena = 1'b1;
    start_rec();
    step(55);
    stop_rec();
    n_checks++;
    if (got_bit != eb) begin
      n_fail++;
      $display("FAIL frac_spacing got=%p exp=%p", got_bit, eb);
    end
  endtask

  task automatic test_async_reset();
    int eb[$];
    int em[$];
    eb = '{0, 1250};
    em = '{625};
    apply_reset();
    load(16'd868, 8'h00);
    @(negedge clk);
    clk_ena = 1'b1;
    step(434);
    #1;
    n_checks++;
    if (tick_mid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_mid got=%b exp=1", tick_mid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (tick_mid !== 1'b0 || tick_bit !== 1'b0 || div_cur !== 16'd1250) begin
      n_fail++;
      $display("FAIL async_reset got mid=%b bit=%b div=%0d exp 0 0 1250", tick_mid, tick_bit, div_cur);
    end
    step(3);
    rst = 1'b0;
    start_rec();
    step(1300);
    stop_rec();
    n_checks++;
    if (got_bit != eb || got_mid != em) begin
      n_fail++;
      $display("FAIL post_reset got bit=%p mid=%p exp bit=%p mid=%p", got_bit, got_mid, eb, em);
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_enable_gap();
    test_load_running();
    test_back_to_back();
    test_load_on_wrap();
    test_div_min();
    test_load_error();
    test_fraction();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
